// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous ROM among NUM_REQ requesters (define ROM_ARB_FIXED_PRIO_EN for fixed priority)
module rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      rom_read,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ROM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic busy_q, busy_d, rom_read_q, rom_read_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // winner: first active request after the pointer, scanned in reverse so the nearest index assigns last
  always_comb begin
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) win = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
  end
  // next-state and registered-output logic for the IDLE/ISSUE/WAIT sequencer
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rom_read_d  = 1'b0;
    rom_addr_d  = rom_addr_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d[win] = 1'b1;
        rom_addr_d = req_addr[win*ADDR_W +: ADDR_W];
        rom_read_d = 1'b1;
        win_d      = win;
        state_d    = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ROM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d          = rom_data;
          rsp_valid_d[win_q]  = 1'b1;
`ifdef ROM_ARB_FIXED_PRIO_EN
          ptr_d               = ptr_q;
`else
          ptr_d               = win_q;
`endif
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers; reset parks the pointer on the last requester so index 0 wins first
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      rom_read_q  <= 1'b0;
      rom_addr_q  <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      rom_read_q  <= rom_read_d;
      rom_addr_q  <= rom_addr_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
    end
  end
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign rom_read  = rom_read_q;
  assign rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven and directed checks of rom_arbiter with ROM latencies 1 and 3
module tb_rom_arbiter;
  localparam int N = 4, AW = 5, DW = 4;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [N-1:0] req_a, gnt_a, rv_a, req_b, gnt_b, rv_b;
  logic [N*AW-1:0] ra_a, ra_b;
  logic [DW-1:0] rd_a, rd_b, romd_a = '0, romd_b;
  logic busy_a, rr_a, busy_b, rr_b;
  logic [AW-1:0] radr_a, radr_b;
  logic [DW-1:0] s1 = '0, s2 = '0, s3 = '0;
  int passed = 0, total = 0;
  rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) dut_a (
    .CLOCK_50(clk), .reset(rst), .req(req_a), .req_addr(ra_a), .gnt(gnt_a), .rsp_valid(rv_a),
    .rsp_data(rd_a), .busy(busy_a), .rom_read(rr_a), .rom_addr(radr_a), .rom_data(romd_a));
  rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3)) dut_b (
    .CLOCK_50(clk), .reset(rst), .req(req_b), .req_addr(ra_b), .gnt(gnt_b), .rsp_valid(rv_b),
    .rsp_data(rd_b), .busy(busy_b), .rom_read(rr_b), .rom_addr(radr_b), .rom_data(romd_b));
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[3:0] ^ 4'hA;
  endfunction
  always @(posedge clk) if (rr_a) romd_a <= mem(radr_a);
  always @(posedge clk) begin
    if (rr_b) s1 <= mem(radr_b);
    s2 <= s1;
    s3 <= s2;
  end
  assign romd_b = s3;
  typedef struct {
    logic rst; logic [N-1:0] req; logic [N*AW-1:0] addr;
    logic [N-1:0] gnt, rv; logic [DW-1:0] rd; logic rr; logic [AW-1:0] ra; logic busy;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N*AW-1:0] ad,
                     input logic [N-1:0] g, v, input logic [DW-1:0] d, input logic rr, input logic [AW-1:0] a, input logic b);
    tv.push_back('{r, rq, ad, g, v, d, rr, a, b});
  endtask
  function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1'b1; req_a = '0; req_b = '0;
    step;
    rst = 1'b0;
  endtask
  logic [31:0] seen;
  logic [N-1:0] grants[$];
  initial begin
    logic [N*AW-1:0] rra;
    rst = 1'b1; req_a = '0; req_b = '0; ra_a = '0; ra_b = '0;
    rra = pa(4, 3, 2, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0100, pa(0, 7, 0, 0), 4'b0100, 0, 0, 1, 7, 1);
    add(0, 0, 0, 0, 0, 0, 0, 7, 1);
    add(0, 0, 0, 0, 4'b0100, 4'hD, 0, 7, 0);
    add(0, 0, 0, 0, 0, 4'hD, 0, 7, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, rra, 4'b0001, 0, 0, 1, 1, 1);
    add(0, 4'hF, rra, 0, 0, 0, 0, 1, 1);
    add(0, 4'hF, rra, 0, 4'b0001, 4'hB, 0, 1, 0);
    add(0, 4'hF, rra, 4'b0010, 0, 4'hB, 1, 2, 1);
    add(0, 4'hF, rra, 0, 0, 4'hB, 0, 2, 1);
    add(0, 4'hF, rra, 0, 4'b0010, 4'h8, 0, 2, 0);
    add(0, 4'hF, rra, 4'b0100, 0, 4'h8, 1, 3, 1);
    add(0, 4'hF, rra, 0, 0, 4'h8, 0, 3, 1);
    add(0, 4'hF, rra, 0, 4'b0100, 4'h9, 0, 3, 0);
    add(0, 4'hF, rra, 4'b1000, 0, 4'h9, 1, 4, 1);
    add(0, 4'hF, rra, 0, 0, 4'h9, 0, 4, 1);
    add(0, 4'hF, rra, 0, 4'b1000, 4'hE, 0, 4, 0);
    add(0, 4'hF, rra, 4'b0001, 0, 4'hE, 1, 1, 1);
    @(negedge clk);
    foreach (tv[i]) begin
      rst = tv[i].rst; req_a = tv[i].req; ra_a = tv[i].addr;
      step;
      chk($sformatf("v%0d gnt", i), gnt_a, tv[i].gnt);
      chk($sformatf("v%0d rsp_valid", i), rv_a, tv[i].rv);
      chk($sformatf("v%0d rsp_data", i), rd_a, tv[i].rd);
      chk($sformatf("v%0d rom_read", i), rr_a, tv[i].rr);
      chk($sformatf("v%0d rom_addr", i), radr_a, tv[i].ra);
      chk($sformatf("v%0d busy", i), busy_a, tv[i].busy);
    end
    do_reset; do_reset;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      step;
      seen |= {gnt_a, rv_a, rd_a, radr_a, rr_a, busy_a, gnt_b, rr_b, busy_b};
    end
    chk("idle quiet", seen, 0);
    do_reset;
    req_a = 4'b0010; ra_a = pa(0, 0, 12, 0);
    step;
    chk("abort gnt", gnt_a, 4'b0010);
    req_a = '0;
    step;
    chk("abort busy in wait", busy_a, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort busy after reset", busy_a, 0);
    seen = {28'b0, rv_a};
    for (int c = 0; c < 4; c++) begin
      step;
      seen |= {28'b0, rv_a};
    end
    chk("abort no rsp_valid", seen, 0);
    req_a = 4'b1001; ra_a = pa(9, 0, 0, 5);
    step;
    chk("after abort gnt", gnt_a, 4'b0001);
    chk("after abort rom_addr", radr_a, 5);
    do_reset;
    req_a = 4'b1001; ra_a = pa(9, 0, 0, 5);
    grants.delete();
    for (int c = 0; c < 12; c++) begin
      step;
      if (gnt_a != 0) grants.push_back(gnt_a);
    end
    req_a = '0;
    chk("1001 grant count", grants.size(), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      chk($sformatf("fixed grant %0d", g), grants[g], 4'b0001);
`else
      chk($sformatf("rr grant %0d", g), grants[g], g % 2 == 0 ? 4'b0001 : 4'b1000);
`endif
    end
    step; step; step;
    req_b = 4'b0010; ra_b = pa(0, 0, 12, 0);
    step;
    chk("lat3 gnt", gnt_b, 4'b0010);
    chk("lat3 rom_read", rr_b, 1);
    chk("lat3 rom_addr 0", radr_b, 12);
    req_b = '0;
    for (int c = 1; c <= 3; c++) begin
      step;
      chk($sformatf("lat3 rom_addr %0d", c), radr_b, 12);
      chk($sformatf("lat3 rom_read %0d", c), rr_b, 0);
      chk($sformatf("lat3 rsp_valid %0d", c), rv_b, 0);
      chk($sformatf("lat3 busy %0d", c), busy_b, 1);
    end
    step;
    chk("lat3 rsp_valid", rv_b, 4'b0010);
    chk("lat3 rsp_data", rd_b, 4'h6);
    chk("lat3 busy done", busy_b, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
